ks_serial_subtractor: RTL
=========================

// Module: ks_serial_subtractor
// PURPOSE
//  Multi-cycle W-bit subtractor: diff = a - b - bin. Processes one 4-bit slice per clock,
//  LSB first, through a 4-bit Kogge-Stone slice computing a + ~b + carry.
//  Provides valid/ready handshakes on both sides plus borrow, zero and signed-overflow flags.
//  It is the subtract-direction companion of the team's 4-bit Kogge-Stone adders, for the
//  datapath and ALU blocks.
// PARAMETERS
//  W       16   operand/result width; must be a multiple of 4 and >= 4
//  NSLICE  W/4  derived: number of slice cycles; not overridable
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operands valid
//  in_ready   out  1  block can accept operands
//  a          in   W  minuend (unsigned or two's complement)
//  b          in   W  subtrahend
//  bin        in   1  borrow in
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  diff       out  W  a - b - bin, modulo 2^W
//  bout       out  1  1 iff unsigned a < b + bin
//  zero       out  1  diff == 0
//  ovf        out  1  signed overflow: a[W-1]!=b[W-1] && diff[W-1]!=a[W-1]
// BEHAVIOUR
//  - FSM states and transitions:
//    - IDLE -> RUN on in_valid && in_ready.
//    - RUN -> DONE after NSLICE slice cycles.
//    - DONE -> IDLE on out_valid && out_ready.
//  - in_ready = (state==IDLE). No accept occurs in RUN or DONE.
//    Throughput is one operation per NSLICE+2 cycles minimum.
//  - Accept edge: latch a, b and idx=0; carry register = ~bin.
//  - Each RUN edge:
//    - ks_sub4(a[4idx+:4], b[4idx+:4], carry) produces s4 and c4.
//    - Write s4 into diff[4idx+:4]; carry <= c4; idx++.
//  - After slice NSLICE-1: bout = ~c4; zero and ovf are computed from the final diff.
//    out_valid rises NSLICE edges after the accepting edge.
//  - DONE: out_valid=1. diff, bout, zero and ovf are held stable until the handshake.
//    They are never updated while out_valid=1.
//  - diff, bout, zero and ovf are don't-care while out_valid=0. The bench checks them
//    only on the handshake.
//  - Inputs a, b and bin are sampled only on the accept edge.
//    Changes during RUN have no effect.
//  - Reset (async, any state, including mid-RUN):
//    - state=IDLE, idx=0, carry=0.
//    - diff=0, bout=0, zero=0, ovf=0, out_valid=0. in_ready=1 while reset is held.
//    - Any partial result is discarded and no out_valid is produced for it.
//  - Simultaneous out handshake and new in_valid in DONE: only the output handshake
//    completes. The new operand is accepted in the following IDLE cycle.
//  - Width rules:
//    - idx width = max(1, $clog2(NSLICE)); idx wraps to 0 on the DONE->IDLE handshake.
//    - All arithmetic is modulo 2^W. There is no internal widening beyond the carry bit.
// STRUCTURE
//  - Shared package ks_pkg:
//    - localparam SLICE_W=4.
//    - typedef enum {IDLE,RUN,DONE} ks_state_t.
//    - Function ks_ovf_sub(a_msb, b_msb, d_msb).
//  - Sub-module ks_sub4: combinational 4-bit Kogge-Stone slice.
//    - Inputs a, b, cin; outputs s, cout.
//    - Internally inverts b: p=a^~b, g=a&~b; two prefix levels; s[0]=p[0]^cin.
//  - Top level: FSM, slice index, carry register, result register, flag logic.
// TESTING (W=16, NSLICE=4)
//  1. a=1234h b=0034h bin=0 -> diff=1200h bout=0 zero=0 ovf=0;
//     out_valid exactly 4 edges after accept.
//  2. a=0000h b=0001h bin=0 -> diff=FFFFh bout=1 zero=0 ovf=0.
//  3. a=8000h b=0001h bin=0 -> diff=7FFFh bout=0 ovf=1;
//     a=7FFFh b=FFFFh -> diff=8000h bout=1 ovf=1.
//  4. a=00FFh b=00FEh bin=1 -> diff=0000h zero=1 bout=0.
//     a=0000h b=0000h bin=1 -> diff=FFFFh bout=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b.
//     -> out_valid, diff and flags stay stable and in_ready=0.
//     Then assert out_ready -> in_ready=1 the next cycle, and the next op is correct.
//  6. Assert rst_n=0 after 2 RUN edges -> out_valid=0 and in_ready=1 immediately.
//     After release, a=FFFFh b=0001h -> diff=FFFEh bout=0 and no stale result appears.
//  7. Random: 10k random a, b, bin with random in_valid/out_ready gaps,
//     checked against a reference {bout,diff} = a - b - bin.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg
//   Shared definitions for the Kogge-Stone serial subtractor family:
//   the slice width, the controller state encoding and the signed
//   overflow rule for subtraction.
package ks_pkg;

  // Width of one arithmetic slice processed per clock.
  localparam int SLICE_W = 4;

  // Controller states: waiting for operands, stepping slices, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_state_t;

  // Signed overflow for a - b. It can only happen when the operand signs differ.
  // It is flagged when the result sign disagrees with the minuend sign.
  function automatic logic ks_ovf_sub(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/ks_sub4.sv
// ks_sub4
//   Combinational 4-bit Kogge-Stone slice computing a + ~b + cin.
//   With cin = ~borrow_in, s is the slice difference and cout is ~borrow_out.
// Ports
//   a    in   4  minuend slice
//   b    in   4  subtrahend slice (inverted internally)
//   cin  in   1  carry in (inverted borrow)
//   s    out  4  difference slice
//   cout out  1  carry out (inverted borrow)
module ks_sub4
  import ks_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] p, g;
  logic [SLICE_W-1:0] p1, g1;
  logic [SLICE_W-1:0] p2, g2;
  logic [SLICE_W:0]   c;

  // Bit-level propagate/generate against the inverted subtrahend.
  assign p = a ^ ~b;
  assign g = a & ~b;

  // Prefix level 1 combines each bit with its neighbour at distance 1.
  assign g1[0] = g[0];
  assign p1[0] = p[0];
  assign g1[1] = g[1] | (p[1] & g[0]);
  assign p1[1] = p[1] & p[0];
  assign g1[2] = g[2] | (p[2] & g[1]);
  assign p1[2] = p[2] & p[1];
  assign g1[3] = g[3] | (p[3] & g[2]);
  assign p1[3] = p[3] & p[2];

  // Prefix level 2 combines at distance 2, giving group terms down to bit 0.
  assign g2[0] = g1[0];
  assign p2[0] = p1[0];
  assign g2[1] = g1[1];
  assign p2[1] = p1[1];
  assign g2[2] = g1[2] | (p1[2] & g1[0]);
  assign p2[2] = p1[2] & p1[0];
  assign g2[3] = g1[3] | (p1[3] & g1[1]);
  assign p2[3] = p1[3] & p1[1];

  // The carry into bit i+1 is the group generate, or the group propagate of cin.
  assign c[0] = cin;
  assign c[1] = g2[0] | (p2[0] & cin);
  assign c[2] = g2[1] | (p2[1] & cin);
  assign c[3] = g2[2] | (p2[2] & cin);
  assign c[4] = g2[3] | (p2[3] & cin);

  assign s    = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/ks_serial_subtractor.sv
// ks_serial_subtractor
//   Multi-cycle W-bit subtractor computing diff = a - b - bin. It processes
//   one 4-bit slice per clock, LSB first, through ks_sub4. Valid/ready
//   handshakes are used on both sides.
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  block can accept operands (IDLE)
//   a          in   W  minuend
//   b          in   W  subtrahend
//   bin        in   1  borrow in
//   out_valid  out  1  result valid (DONE)
//   out_ready  in   1  consumer accepts result
//   diff       out  W  a - b - bin modulo 2^W
//   bout       out  1  unsigned borrow out
//   zero       out  1  diff == 0
//   ovf        out  1  signed overflow
// W must be a multiple of 4 and at least 4.
module ks_serial_subtractor
  import ks_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int NSLICE = W / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  ks_state_t          state, state_next;
  logic [IDXW-1:0]    idx;
  logic               carry;
  logic [W-1:0]       a_reg, b_reg;
  logic [W-1:0]       diff_next;
  logic [SLICE_W-1:0] s4;
  logic               c4;
  logic               accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  ks_sub4 u_slice (
    .a    (a_reg[SLICE_W*idx +: SLICE_W]),
    .b    (b_reg[SLICE_W*idx +: SLICE_W]),
    .cin  (carry),
    .s    (s4),
    .cout (c4)
  );

  // Result with the current slice merged in. This lets the zero and overflow
  // flags on the final slice see the complete difference in the same edge.
  always_comb begin
    diff_next = diff;
    diff_next[SLICE_W*idx +: SLICE_W] = s4;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state. In DONE only the output handshake is honoured.
  // A new operand waits for the following IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Operands are captured once at accept, and the carry starts as ~bin.
  // Each RUN edge writes one slice. The flags are set on the last slice.
  // Results are frozen throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= ~bin;
      idx   <= '0;
    end else if (state == RUN) begin
      diff  <= diff_next;
      carry <= c4;
      if (idx == LAST_IDX) begin
        bout <= ~c4;
        zero <= (diff_next == '0);
        ovf  <= ks_ovf_sub(a_reg[W-1], b_reg[W-1], diff_next[W-1]);
      end else begin
        idx <= idx + IDXW'(1);
      end
    end else if (out_valid && out_ready) begin
      idx <= '0;
    end
  end

endmodule
